// File: rtl/npc_pkg.sv
// Shared NPC definitions: arbiter FSM states, owner encoding and the
// default address/data widths used by the memory-side blocks.
package npc_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // Arbiter transaction phases
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Which requester owns the outstanding transaction
   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

endpackage

// File: rtl/arb2_rr.sv
// Two-way round-robin grant between IFU and LSU. On a tie the side that
// did not win last time is granted; nothing is granted while disabled.
module arb2_rr (
   input  logic en,
   input  logic ifu_valid,
   input  logic lsu_valid,
   input  logic last_lsu,
   output logic ifu_gnt,
   output logic lsu_gnt
);

   // Purely combinational grant, mutually exclusive by construction
   always_comb begin
      ifu_gnt = en && ifu_valid && (!lsu_valid || last_lsu);
      lsu_gnt = en && lsu_valid && (!ifu_valid || !last_lsu);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single NPC memory port between IFU and LSU. One transaction
// is in flight at a time; its fields are latched at grant and held on the
// memory side until accepted, and the response is steered to the owner.
module mem_arbiter
   import npc_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   // IFU side
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_resp_data,
   // LSU side
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_resp_data,
   // Memory side
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data
);

   state_t state;
   owner_t owner;
   logic   last_lsu;
   logic   arb_en;
   logic   ifu_gnt;
   logic   lsu_gnt;

   // Grants are only offered while no transaction is outstanding
   assign arb_en = (state == ST_IDLE);

   arb2_rr u_arb (
      .en        (arb_en),
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .last_lsu  (last_lsu),
      .ifu_gnt   (ifu_gnt),
      .lsu_gnt   (lsu_gnt)
   );

   assign ifu_req_ready = ifu_gnt;
   assign lsu_req_ready = lsu_gnt;

   // Transaction FSM with latched request fields and registered responses.
   // last_lsu resets to 1 so the IFU wins the very first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         owner          <= OWN_IFU;
         last_lsu       <= 1'b1;
         mem_req_valid  <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         ifu_resp_data  <= '0;
         lsu_resp_valid <= 1'b0;
         lsu_resp_data  <= '0;
      end else begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ifu_gnt || lsu_gnt) begin
                  owner         <= lsu_gnt ? OWN_LSU : OWN_IFU;
                  last_lsu      <= lsu_gnt;
                  // Fetches are always plain reads with no byte strobes
                  mem_addr      <= lsu_gnt ? lsu_addr  : ifu_addr;
                  mem_wen       <= lsu_gnt && lsu_wen;
                  mem_wdata     <= lsu_gnt ? lsu_wdata : '0;
                  mem_wmask     <= lsu_gnt ? lsu_wmask : '0;
                  mem_req_valid <= 1'b1;
                  state         <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_resp_valid) begin
                  if (owner == OWN_LSU) begin
                     lsu_resp_data  <= mem_resp_data;
                     lsu_resp_valid <= 1'b1;
                  end else begin
                     ifu_resp_data  <= mem_resp_data;
                     ifu_resp_valid <= 1'b1;
                  end
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions with
// memory stalls, plus sequences for round-robin, reset abort and a
// spurious memory response.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_data;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_data  (ifu_resp_data),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_data  (lsu_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   typedef struct {
      logic        is_lsu;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      int          req_stall;
      int          resp_stall;
      logic        exp_wen;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wmask;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_fields(input string tag, input vec_t v);
      chk({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'd1);
      chk({tag, " mem_addr"},      64'(mem_addr),      64'(v.addr));
      chk({tag, " mem_wen"},       64'(mem_wen),       64'(v.exp_wen));
      chk({tag, " mem_wdata"},     64'(mem_wdata),     64'(v.exp_wdata));
      chk({tag, " mem_wmask"},     64'(mem_wmask),     64'(v.exp_wmask));
   endtask

   // One complete transaction starting in IDLE at a negedge
   task automatic run_txn(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      ifu_req_valid = !v.is_lsu;
      lsu_req_valid = v.is_lsu;
      ifu_addr      = v.addr;
      lsu_addr      = v.addr;
      lsu_wen       = v.wen;
      lsu_wdata     = v.wdata;
      lsu_wmask     = v.wmask;
      #1;
      chk({tag, " grant"}, {63'd0, v.is_lsu ? lsu_req_ready : ifu_req_ready}, 64'd1);
      chk({tag, " no cross grant"}, {63'd0, v.is_lsu ? ifu_req_ready : lsu_req_ready}, 64'd0);
      @(negedge clk);
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      chk_fields({tag, " req"}, v);
      for (int i = 0; i < v.req_stall; i++) begin
         ifu_req_valid = 1'b1;
         lsu_req_valid = 1'b1;
         #1;
         chk({tag, " stall ready"}, {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
         @(negedge clk);
         chk_fields({tag, " stall"}, v);
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({tag, " req dropped"}, 64'(mem_req_valid), 64'd0);
      for (int i = 0; i < v.resp_stall; i++) begin
         @(negedge clk);
         chk({tag, " wait no resp"}, {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
         chk({tag, " wait addr"}, 64'(mem_addr), 64'(v.addr));
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = v.rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      chk({tag, " resp valids"}, {62'd0, ifu_resp_valid, lsu_resp_valid},
          v.is_lsu ? 64'd1 : 64'd2);
      chk({tag, " resp data"}, 64'(v.is_lsu ? lsu_resp_data : ifu_resp_data), 64'(v.rdata));
      @(negedge clk);
      chk({tag, " resp one cycle"}, {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //       lsu   addr          wen   wdata         wmask    rdata       rs ws ewen  ewdata        ewmask
      vecs[0] = '{1'b0, 32'h8000_0000, 1'b1, 32'h1111_1111, 4'b1111, 32'h0000_0413, 0, 0, 1'b0, 32'h0,         4'b0000};
      vecs[1] = '{1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678, 0, 0, 1'b1, 32'hDEAD_BEEF, 4'b0011};
      vecs[2] = '{1'b1, 32'h8000_2004, 1'b0, 32'h0BAD_0BAD, 4'b0110, 32'hCAFE_F00D, 5, 3, 1'b0, 32'h0BAD_0BAD, 4'b0110};
      vecs[3] = '{1'b0, 32'h8000_0004, 1'b0, 32'h2222_2222, 4'b1010, 32'h0010_0073, 2, 1, 1'b0, 32'h0,         4'b0000};
      vecs[4] = '{1'b1, 32'h8000_3000, 1'b1, 32'hA5A5_5A5A, 4'b1111, 32'h0000_0000, 0, 4, 1'b1, 32'hA5A5_5A5A, 4'b1111};

      rst            = 1'b1;
      ifu_req_valid  = 1'b0;
      lsu_req_valid  = 1'b0;
      ifu_addr       = 32'h8000_0100;
      lsu_addr       = 32'h8000_0200;
      lsu_wen        = 1'b0;
      lsu_wdata      = 32'h0;
      lsu_wmask      = 4'h0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("reset valids", {59'd0, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 64'd0);
      chk("reset mem_addr", 64'(mem_addr), 64'd0);
      chk("reset mem_fields", {27'd0, mem_wen, mem_wdata, mem_wmask}, 64'd0);
      chk("reset resp data", {ifu_resp_data, lsu_resp_data}, 64'd0);

      // Both requesters valid from the first cycle out of reset
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rr%0d grant", k), {62'd0, ifu_req_ready, lsu_req_ready},
             (k % 2 == 0) ? 64'd2 : 64'd1);
         @(negedge clk);
         chk($sformatf("rr%0d addr", k), 64'(mem_addr),
             (k % 2 == 0) ? 64'h8000_0100 : 64'h8000_0200);
         chk($sformatf("rr%0d busy ready", k), {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'h100 + k;
         @(negedge clk);
         mem_resp_valid = 1'b0;
         chk($sformatf("rr%0d resp owner", k), {62'd0, ifu_resp_valid, lsu_resp_valid},
             (k % 2 == 0) ? 64'd2 : 64'd1);
         chk($sformatf("rr%0d resp data", k),
             64'((k % 2 == 0) ? ifu_resp_data : lsu_resp_data), 64'(32'h100 + k));
         @(negedge clk);
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;

      // Table of single transactions
      for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

      // Reset while waiting for the memory response
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0040;
      @(negedge clk);
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort outputs", {61'd0, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 64'd0);
      chk("abort addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("late resp ignored", {61'd0, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 64'd0);
      @(negedge clk);
      chk("late resp data", 64'(ifu_resp_data), 64'd0);
      run_txn(vecs[0], 10);

      // Spurious response while idle
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h5555_AAAA;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("spurious no pulse", {61'd0, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 64'd0);
      @(negedge clk);
      chk("spurious no pulse2", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      chk("spurious data kept", 64'(ifu_resp_data), 64'h0000_0413);
      run_txn(vecs[1], 11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
